// File: rtl/color_pkg.sv
// Shared types and helpers for the button-driven RGB color selector.
package color_pkg;

    localparam int NUM_COLORS = 6;

    typedef logic [2:0] color_idx_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESSED  = 2'd1,
        LONG     = 2'd2,
        WAIT_REL = 2'd3
    } state_t;

    // Returns {R,G,B} active-low; unreachable indices fall back to off.
    function automatic logic [2:0] decode_rgb_n(input color_idx_t idx);
        logic [2:0] rgb_n;
        case (idx)
            3'd0:    rgb_n = 3'b011;
            3'd1:    rgb_n = 3'b001;
            3'd2:    rgb_n = 3'b101;
            3'd3:    rgb_n = 3'b110;
            3'd4:    rgb_n = 3'b010;
            default: rgb_n = 3'b111;
        endcase
        return rgb_n;
    endfunction

    function automatic color_idx_t next_color(input color_idx_t idx);
        color_idx_t nxt;
        if (idx >= color_idx_t'(NUM_COLORS - 1)) begin
            nxt = 3'd0;
        end else begin
            nxt = idx + 3'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a consecutive-cycle level debouncer (active-low in, active-low out).
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 240000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_n,
    output logic level
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_r;
    logic          sync2_r;
    logic          level_r;
    logic [CW-1:0] cnt_r;

    // Synchronizer; resets to the released level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= raw_n;
            sync2_r <= sync1_r;
        end
    end

    // Accept a new level only after it has differed for the full window.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_r <= 1'b1;
            cnt_r   <= {CW{1'b0}};
        end else if (sync2_r != level_r) begin
            if (cnt_r == CNT_LAST) begin
                level_r <= sync2_r;
                cnt_r   <= {CW{1'b0}};
            end else begin
                cnt_r   <= cnt_r + CW'(1);
            end
        end else begin
            cnt_r <= {CW{1'b0}};
        end
    end

    assign level = level_r;

endmodule

// File: rtl/button_color_sel.sv
// Pushbutton color selector: short press advances the color, long press resets it
// (or, with AUTO_CYCLE_EN defined, toggles timed auto-cycling).
module button_color_sel
    import color_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = 240000,
    parameter int LONG_PRESS_CYCLES = 12000000,
    parameter int STEP_INTERVAL     = 2000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       BTN_N,
    output logic [2:0] color_idx,
    output logic       press_pulse,
    output logic       long_pulse,
    output logic       RGB_R,
    output logic       RGB_G,
    output logic       RGB_B
);

    localparam int HW = (LONG_PRESS_CYCLES > 1) ? $clog2(LONG_PRESS_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);

    logic          level_s;
    state_t        state_r;
    state_t        state_s;
    logic          press_s;
    logic          long_s;
    logic          press_pulse_r;
    logic          long_pulse_r;
    logic [HW-1:0] hold_cnt_r;
    color_idx_t    color_idx_r;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .rst   (rst),
        .raw_n (BTN_N),
        .level (level_s)
    );

    // State register and registered strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            press_pulse_r <= 1'b0;
            long_pulse_r  <= 1'b0;
        end else begin
            state_r       <= state_s;
            press_pulse_r <= press_s;
            long_pulse_r  <= long_s;
        end
    end

    // Next state; press_s/long_s mark the edge on which each event is accepted.
    always_comb begin
        state_s = state_r;
        press_s = 1'b0;
        long_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (!level_s) begin
                    state_s = PRESSED;
                end else begin
                    state_s = IDLE;
                end
            end
            PRESSED: begin
                if (level_s) begin
                    state_s = IDLE;
                    press_s = 1'b1;
                end else if (hold_cnt_r == HOLD_LAST) begin
                    state_s = LONG;
                    long_s  = 1'b1;
                end else begin
                    state_s = PRESSED;
                end
            end
            LONG: begin
                state_s = WAIT_REL;
            end
            WAIT_REL: begin
                if (level_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT_REL;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Hold counter: zero outside PRESSED, saturating while held.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_r <= {HW{1'b0}};
        end else if (state_r != PRESSED) begin
            hold_cnt_r <= {HW{1'b0}};
        end else if (hold_cnt_r != HOLD_LAST) begin
            hold_cnt_r <= hold_cnt_r + HW'(1);
        end else begin
            hold_cnt_r <= hold_cnt_r;
        end
    end

`ifdef AUTO_CYCLE_EN
    localparam int SW = (STEP_INTERVAL > 1) ? $clog2(STEP_INTERVAL) : 1;
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_INTERVAL - 1);

    logic          auto_r;
    logic [SW-1:0] step_cnt_r;

    // Color index with auto-cycling; a short press wins over a coincident step.
    always_ff @(posedge clk) begin
        if (rst) begin
            color_idx_r <= 3'd0;
            auto_r      <= 1'b0;
            step_cnt_r  <= {SW{1'b0}};
        end else if (press_s) begin
            color_idx_r <= next_color(color_idx_r);
            step_cnt_r  <= {SW{1'b0}};
        end else if (long_s) begin
            auto_r      <= ~auto_r;
            step_cnt_r  <= {SW{1'b0}};
        end else if (auto_r) begin
            if (step_cnt_r == STEP_LAST) begin
                color_idx_r <= next_color(color_idx_r);
                step_cnt_r  <= {SW{1'b0}};
            end else begin
                step_cnt_r  <= step_cnt_r + SW'(1);
            end
        end else begin
            step_cnt_r <= {SW{1'b0}};
        end
    end
`else
    // Color index: short press advances, long press returns to red.
    always_ff @(posedge clk) begin
        if (rst) begin
            color_idx_r <= 3'd0;
        end else if (press_s) begin
            color_idx_r <= next_color(color_idx_r);
        end else if (long_s) begin
            color_idx_r <= 3'd0;
        end else begin
            color_idx_r <= color_idx_r;
        end
    end
`endif

    assign color_idx             = color_idx_r;
    assign press_pulse           = press_pulse_r;
    assign long_pulse            = long_pulse_r;
    assign {RGB_R, RGB_G, RGB_B} = decode_rgb_n(color_idx_r);

endmodule

// File: tb/tb_button_color_sel.sv
// Directed bench for button_color_sel; expected pulse events are queued at stimulus time
// and popped when the DUT strobes. Define AUTO_CYCLE_EN to also cover auto-cycling.
module tb_button_color_sel;

    typedef struct packed {
        logic [1:0] kind;   // {press_pulse, long_pulse}
        logic [2:0] color;
        logic       chk;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       BTN_N = 1'b1;
    logic [2:0] color_idx;
    logic       press_pulse;
    logic       long_pulse;
    logic       RGB_R;
    logic       RGB_G;
    logic       RGB_B;

    exp_t       sb[$];
    exp_t       e;
    int         n_assert = 0;
    int         n_fail = 0;
    logic [2:0] exp_color = 3'd0;
    logic       track = 1'b0;
    logic       auto_m = 1'b0;
    int         step_m = 0;

    button_color_sel #(
        .DEBOUNCE_CYCLES  (4),
        .LONG_PRESS_CYCLES(20),
        .STEP_INTERVAL    (10)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .BTN_N      (BTN_N),
        .color_idx  (color_idx),
        .press_pulse(press_pulse),
        .long_pulse (long_pulse),
        .RGB_R      (RGB_R),
        .RGB_G      (RGB_G),
        .RGB_B      (RGB_B)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (press_pulse || long_pulse) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", 32'({press_pulse, long_pulse}), 32'd0);
            end else begin
                e = sb.pop_front();
                check("pulse_kind", 32'({press_pulse, long_pulse}), 32'(e.kind));
                if (e.chk) check("color_at_pulse", 32'(color_idx), 32'(e.color));
                if (long_pulse) begin
                    auto_m = ~auto_m;
                    step_m = 0;
                end
            end
        end else if (auto_m) begin
            step_m++;
            if (step_m == 10) begin
                step_m = 0;
                exp_color = (exp_color == 3'd5) ? 3'd0 : exp_color + 3'd1;
            end
        end
        if (track) check("auto_color", 32'(color_idx), 32'(exp_color));
    endtask

    task automatic short_press();
        exp_color = (exp_color == 3'd5) ? 3'd0 : exp_color + 3'd1;
        sb.push_back('{kind: 2'b10, color: exp_color, chk: 1'b1});
        BTN_N = 1'b0;
        repeat (10) tick();
        BTN_N = 1'b1;
        repeat (12) tick();
        check("press_missing", 32'(sb.size()), 32'd0);
    endtask

    task automatic long_press();
`ifdef AUTO_CYCLE_EN
        sb.push_back('{kind: 2'b01, color: 3'd0, chk: 1'b0});
`else
        exp_color = 3'd0;
        sb.push_back('{kind: 2'b01, color: 3'd0, chk: 1'b1});
`endif
        BTN_N = 1'b0;
        repeat (40) tick();
        BTN_N = 1'b1;
        repeat (12) tick();
        check("long_missing", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        check("rst_color", 32'(color_idx), 32'd0);
        check("rst_press", 32'(press_pulse), 32'd0);
        check("rst_long", 32'(long_pulse), 32'd0);
        check("rst_rgb", 32'({RGB_R, RGB_G, RGB_B}), 32'b011);
        rst = 1'b0;
        repeat (2) tick();

        // One short press: red -> yellow
        short_press();
        check("yellow_rgb", 32'({RGB_R, RGB_G, RGB_B}), 32'b001);

        // Bounce every 2 cycles must be rejected
        for (int i = 0; i < 20; i++) begin
            BTN_N = ~BTN_N;
            repeat (2) tick();
        end
        BTN_N = 1'b1;
        repeat (12) tick();
        check("bounce_color", 32'(color_idx), 32'(exp_color));

        // Six presses from reset walk through every color and wrap
        rst = 1'b1;
        exp_color = 3'd0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) begin
            short_press();
            if (i == 4) check("off_rgb", 32'({RGB_R, RGB_G, RGB_B}), 32'b111);
        end

        // Reset mid-hold abandons the press
        short_press();
        BTN_N = 1'b0;
        repeat (20) tick();
        rst = 1'b1;
        exp_color = 3'd0;
        repeat (3) tick();
        check("midrst_color", 32'(color_idx), 32'd0);
        check("midrst_press", 32'(press_pulse), 32'd0);
        check("midrst_long", 32'(long_pulse), 32'd0);
        check("midrst_rgb", 32'({RGB_R, RGB_G, RGB_B}), 32'b011);
        rst = 1'b0;
        repeat (2) tick();
        BTN_N = 1'b1;
        repeat (15) tick();
        check("postrst_color", 32'(color_idx), 32'd0);
        short_press();

`ifdef AUTO_CYCLE_EN
        // Long press starts auto-cycling; a second one stops it
        track = 1'b1;
        long_press();
        repeat (35) tick();
        long_press();
        repeat (25) tick();
        check("auto_off", 32'(auto_m), 32'd0);
        track = 1'b0;
`else
        // Long press returns to red with no press strobe on release
        long_press();
        check("long_color", 32'(color_idx), 32'd0);
        check("long_rgb", 32'({RGB_R, RGB_G, RGB_B}), 32'b011);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/button_color_sel.md
BUTTON_COLOR_SEL -- requirements
Module: button_color_sel

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 240000, stable-input cycles required to accept a level change (20 ms at 12 MHz).
REQ-002 SHALL have parameter LONG_PRESS_CYCLES, default 12000000, debounced-held cycles that qualify a long press (1 s).
REQ-003 SHALL have parameter STEP_INTERVAL, default 2000000, auto-cycle step period in cycles (only used when AUTO_CYCLE_EN is defined).
REQ-004 SHALL have port clk  input  1  12 MHz system clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port BTN_N  input  1  raw pushbutton, active-low, asynchronous to clk, bouncy.
REQ-007 SHALL have port color_idx  output  3  current color index, 0..5.
REQ-008 SHALL have port press_pulse  output  1  one-cycle strobe on each accepted short press.
REQ-009 SHALL have port long_pulse  output  1  one-cycle strobe when a long press qualifies.
REQ-010 SHALL have ports RGB_R, RGB_G, RGB_B  output  1 each  active-low LED drives.

Function
REQ-011 SHALL pass BTN_N through a 2-flop synchronizer before any other use; the synchronizer resets to 1 (released).
REQ-012 SHALL change the debounced level only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any return to the debounced value restarts the count at 0.
REQ-013 SHALL run FSM states IDLE, PRESSED, LONG, WAIT_REL; IDLE->PRESSED on debounced press; PRESSED->IDLE on debounced release; PRESSED->LONG when the hold counter reaches LONG_PRESS_CYCLES-1; LONG->WAIT_REL unconditionally next cycle; WAIT_REL->IDLE on debounced release.
REQ-014 SHALL assert press_pulse for exactly one cycle on the PRESSED->IDLE transition and advance color_idx in the same cycle, wrapping 5->0.
REQ-015 SHALL assert long_pulse for exactly one cycle while in LONG; release from WAIT_REL SHALL NOT produce press_pulse or advance color_idx.
REQ-016 SHALL saturate the hold counter at LONG_PRESS_CYCLES-1; counter clears on entry to PRESSED.
REQ-017 SHALL decode color_idx combinationally: 0 red (R low), 1 yellow (R,G low), 2 green (G low), 3 blue (B low), 4 purple (R,B low), 5 off (all high); values 6,7 unreachable, decode as off.
REQ-018 SHALL never assert press_pulse and long_pulse in the same cycle.

Reset
REQ-019 SHALL, while rst is high, force: FSM IDLE, debounced level released, all counters 0, color_idx 0, press_pulse 0, long_pulse 0, auto mode off; RGB outputs therefore red (RGB_R=0, RGB_G=1, RGB_B=1).
REQ-020 SHALL abandon a press in progress when rst asserts; a button still held after rst deasserts SHALL be accepted as a new press only after DEBOUNCE_CYCLES.

Configuration
REQ-021 SHALL support macro AUTO_CYCLE_EN; when defined, long_pulse toggles an auto mode flag, and in auto mode color_idx advances every STEP_INTERVAL cycles (wrap 5->0) with the step counter cleared on every toggle and on any short-press advance.
REQ-022 SHALL, when AUTO_CYCLE_EN is undefined, make long_pulse set color_idx to 0 and omit the step counter and mode flag entirely.
REQ-023 SHALL, with AUTO_CYCLE_EN, give a short-press advance precedence over a coincident auto step (single increment only).

Structure
REQ-024 SHALL place NUM_COLORS (6), the color index typedef, the FSM state enum and the index-to-RGB decode function in shared package color_pkg.
REQ-025 SHALL implement synchronizer plus debounce as sub-module btn_debounce (ports clk, rst, raw_n, level), instantiated once.

Verification (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, STEP_INTERVAL=10)
REQ-026 SHALL cover: BTN_N low for 10 cycles then high -> one press_pulse, color_idx 0->1, RGB_R=0 RGB_G=0 RGB_B=1.
REQ-027 SHALL cover: BTN_N toggling every 2 cycles for 40 cycles -> no press_pulse, color_idx unchanged.
REQ-028 SHALL cover: six clean short presses from reset -> color_idx sequence 1,2,3,4,5,0; at 5 all RGB high.
REQ-029 SHALL cover: BTN_N low for 40 cycles -> exactly one long_pulse, no press_pulse on release; without AUTO_CYCLE_EN color_idx=0.
REQ-030 SHALL cover (AUTO_CYCLE_EN): long press then idle 35 cycles -> color_idx advances every 10 cycles; second long press -> stepping stops.
REQ-031 SHALL cover: rst asserted mid-hold with BTN_N low -> outputs at reset values; after release, no pulse until a fresh debounced press.
